// File: rtl/ex_stage_pipe.sv
// Execute stage: forwarding operand mux, ALU, iterative multiplier,
// and the EX/MEM pipeline register.
module ex_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [2:0]        alu_op,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              reg_write_in,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [DATA_W-1:0] wb_data_W,
  input  logic              stall_in,
  input  logic              flush,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] result_M,
  output logic [DATA_W-1:0] store_data_M,
  output logic [REG_W-1:0]  rd_M,
  output logic              regWrite_M
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_store;
  logic [REG_W-1:0]  r_rd;
  logic              r_regw;

  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_mul_step;
  logic              w_is_mul;
  logic              w_mul_last;

  assign w_is_mul   = (alu_op == 3'b111);
  assign w_mul_last = (r_cnt == LAST);
  assign w_alu_b    = use_imm ? imm : w_opb;
  assign w_mul_step = r_mplier[0] ? r_acc + r_mcand : r_acc;

  // Operand select: MEM result, write-back data, or register file.
  always_comb begin
    w_opa = rs1_val;
    w_opb = rs2_val;
    unique case (ForwardA)
      2'b10:   w_opa = r_result;
      2'b01:   w_opa = wb_data_W;
      default: w_opa = rs1_val;
    endcase
    unique case (ForwardB)
      2'b10:   w_opb = r_result;
      2'b01:   w_opb = wb_data_W;
      default: w_opb = rs2_val;
    endcase
  end

  // Single-cycle ALU; multiply goes through the iterative path.
  always_comb begin
    w_alu = '0;
    unique case (alu_op)
      3'b000:  w_alu = w_opa + w_alu_b;
      3'b001:  w_alu = w_opa - w_alu_b;
      3'b010:  w_alu = w_opa & w_alu_b;
      3'b011:  w_alu = w_opa | w_alu_b;
      3'b100:  w_alu = w_opa ^ w_alu_b;
      3'b101:  w_alu = {{(DATA_W-1){1'b0}},
                        ($signed(w_opa) < $signed(w_alu_b))};
      3'b110:  w_alu = w_opa << w_alu_b[4:0];
      default: w_alu = '0;
    endcase
  end

  assign busy = stall_in
              | ((r_state == S_IDLE) & in_valid & w_is_mul)
              | ((r_state == S_MUL) & ~w_mul_last);

  // EX/MEM register and multiply sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_store  <= '0;
      r_rd     <= '0;
      r_regw   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_regw  <= 1'b0;
    end else if (!stall_in) begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && w_is_mul) begin
            r_mcand  <= w_opa;
            r_mplier <= w_alu_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL;
            r_store  <= w_opb;
            r_valid  <= 1'b0;
            r_rd     <= '0;
            r_regw   <= 1'b0;
          end else if (in_valid) begin
            r_result <= w_alu;
            r_store  <= w_opb;
            r_rd     <= rd_in;
            r_regw   <= reg_write_in;
            r_valid  <= 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_regw  <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc    <= w_mul_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_result <= w_mul_step;
            r_rd     <= rd_in;
            r_regw   <= reg_write_in;
            r_valid  <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid    = r_valid;
  assign result_M     = r_result;
  assign store_data_M = r_store;
  assign rd_M         = r_rd;
  assign regWrite_M   = r_regw;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe with a behavioural
// reference model of the execute stage.
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] rs1_val, rs2_val, imm;
  logic        use_imm;
  logic [2:0]  alu_op;
  logic [31:0] rd_in;
  logic        reg_write_in;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] wb_data_W;
  logic        stall_in, flush;
  logic        busy, out_valid;
  logic [31:0] result_M, store_data_M, rd_M;
  logic        regWrite_M;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_res;

  always #5 clk = ~clk;

  ex_stage_pipe #(.DATA_W(32), .REG_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .use_imm(use_imm), .alu_op(alu_op), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .ForwardA(ForwardA),
    .ForwardB(ForwardB), .wb_data_W(wb_data_W),
    .stall_in(stall_in), .flush(flush), .busy(busy),
    .out_valid(out_valid), .result_M(result_M),
    .store_data_M(store_data_M), .rd_M(rd_M),
    .regWrite_M(regWrite_M)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    int signed sa, sb;
    sh = b[4:0];
    sa = a;
    sb = b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd6:    return a << sh;
      default: return a * b;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel,
                                      input logic [31:0] rs,
                                      input logic [31:0] wb);
    if (sel == 2'b10) return m_res;
    if (sel == 2'b01) return wb;
    return rs;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] wb,
                       input logic [31:0] rd, input logic rw);
    in_valid = 1'b1; alu_op = op; rs1_val = a; rs2_val = b;
    ForwardA = fa; ForwardB = fb; wb_data_W = wb;
    rd_in = rd; reg_write_in = rw; use_imm = 1'b0; imm = '0;
  endtask

  // Clocks until the instruction is accepted (busy low before an edge).
  task automatic run(output int edges, output bit to);
    bit b;
    edges = 0;
    to = 1'b0;
    forever begin
      #1;
      b = busy;
      step();
      edges++;
      if (!b) break;
      if (edges > 100) begin
        to = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    drive(3'd0, 0, 0, 2'b00, 2'b00, 0, 0, 1'b0);
    in_valid = 1'b0;
    #12;
    n_vec++;
    if ({out_valid, regWrite_M, busy} !== 3'b000 ||
        result_M !== 0 || store_data_M !== 0 || rd_M !== 0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b rw=%b busy=%b res=%h st=%h rd=%h want all 0",
               out_valid, regWrite_M, busy, result_M, store_data_M, rd_M);
    end
    reset_n = 1'b1;
    m_res = '0;
    step();
  endtask

  task automatic test_add();
    int e; bit to;
    drive(3'd0, 5, 7, 2'b00, 2'b00, 0, 3, 1'b1);
    run(e, to);
    n_vec++;
    if (to || e != 1 || result_M !== 32'd12 || rd_M !== 32'd3 ||
        regWrite_M !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL add_basic: edges=%0d res=%h rd=%h rw=%b v=%b want 1/c/3/1/1",
               e, result_M, rd_M, regWrite_M, out_valid);
    end
    m_res = 32'd12;
  endtask

  task automatic test_back_to_back();
    int e; bit to;
    logic [31:0] want;
    drive(3'd0, 5, 7, 2'b00, 2'b00, 0, 1, 1'b1);
    run(e, to);
    n_vec++;
    if (result_M !== 32'd12) begin
      n_err++;
      $display("FAIL b2b_first: got %h want 0000000c", result_M);
    end
    m_res = 32'd12;
    drive(3'd1, 0, 2, 2'b10, 2'b01, 99, 2, 1'b1);
    want = 32'd12 - 32'd99;
    run(e, to);
    n_vec++;
    if (to || e != 1 || result_M !== want || store_data_M !== 32'd99) begin
      n_err++;
      $display("FAIL b2b_sub_fwd: edges=%0d res=%h st=%h want 1 %h 00000063",
               e, result_M, store_data_M, want);
    end
    m_res = want;
  endtask

  task automatic test_mul();
    int e, nbusy, badv;
    bit b;
    e = 0; nbusy = 0; badv = 0;
    drive(3'd7, 32'h0001_0003, 0, 2'b00, 2'b01, 5, 9, 1'b1);
    for (int g = 0; g < 100; g++) begin
      if (e == 12) wb_data_W = 32'h1234_5678;
      #1;
      b = busy;
      if (b) nbusy++;
      step();
      e++;
      if (!b) break;
      if (out_valid !== 1'b0) badv++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (nbusy != 32 || e != 33) begin
      n_err++;
      $display("FAIL mul_busy: busy_cycles=%0d edges=%0d want 32 33", nbusy, e);
    end
    n_vec++;
    if (badv != 0) begin
      n_err++;
      $display("FAIL mul_bubble: valid-high cycles=%0d want 0", badv);
    end
    n_vec++;
    if (result_M !== 32'h0005_000F || out_valid !== 1'b1 ||
        rd_M !== 32'd9 || regWrite_M !== 1'b1) begin
      n_err++;
      $display("FAIL mul_result: res=%h v=%b rd=%h rw=%b want 0005000f 1 9 1",
               result_M, out_valid, rd_M, regWrite_M);
    end
    m_res = 32'h0005_000F;
  endtask

  task automatic test_flush_mul();
    int e; bit to;
    drive(3'd7, 3, 4, 2'b00, 2'b00, 0, 4, 1'b1);
    for (int k = 0; k < 10; k++) step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || regWrite_M !== 1'b0 || rd_M !== 0 ||
        busy !== 1'b0 || result_M !== m_res) begin
      n_err++;
      $display("FAIL flush_mul: v=%b rw=%b rd=%h busy=%b res=%h want 0 0 0 0 %h",
               out_valid, regWrite_M, rd_M, busy, result_M, m_res);
    end
    drive(3'd0, 1, 1, 2'b00, 2'b00, 0, 5, 1'b1);
    run(e, to);
    n_vec++;
    if (to || e != 1 || result_M !== 32'd2 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_then_add: edges=%0d res=%h v=%b want 1 2 1",
               e, result_M, out_valid);
    end
    m_res = 32'd2;
  endtask

  task automatic test_stall();
    int e, bad;
    bit b, to;
    bad = 0;
    drive(3'd0, 3, 4, 2'b00, 2'b00, 0, 6, 1'b1);
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (busy !== 1'b1) bad++;
      step();
      if (result_M !== m_res || out_valid !== 1'b1) bad++;
    end
    stall_in = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_add_hold: %0d frozen-state errors want 0", bad);
    end
    run(e, to);
    n_vec++;
    if (to || e != 1 || result_M !== 32'd7) begin
      n_err++;
      $display("FAIL stall_add_result: edges=%0d res=%h want 1 7", e, result_M);
    end
    m_res = 32'd7;
    bad = 0; e = 0;
    drive(3'd7, 6, 7, 2'b00, 2'b00, 0, 7, 1'b1);
    for (int g = 0; g < 100; g++) begin
      stall_in = (e >= 5 && e < 8);
      #1;
      b = busy;
      if (stall_in && !b) bad++;
      step();
      e++;
      if (!b) break;
    end
    stall_in = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (bad != 0 || e != 36 || result_M !== 32'd42) begin
      n_err++;
      $display("FAIL stall_mul: busy_errs=%0d edges=%0d res=%h want 0 36 0000002a",
               bad, e, result_M);
    end
    m_res = 32'd42;
  endtask

  task automatic test_reset_mid_mul();
    int e; bit to;
    drive(3'd7, 9, 9, 2'b00, 2'b00, 0, 8, 1'b1);
    for (int k = 0; k < 10; k++) step();
    #3;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || regWrite_M !== 1'b0 || rd_M !== 0 ||
        result_M !== 0 || store_data_M !== 0) begin
      n_err++;
      $display("FAIL async_reset: v=%b rw=%b rd=%h res=%h st=%h want all 0",
               out_valid, regWrite_M, rd_M, result_M, store_data_M);
    end
    in_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    m_res = '0;
    step();
    drive(3'd0, 2, 2, 2'b00, 2'b00, 0, 1, 1'b1);
    run(e, to);
    n_vec++;
    if (to || e != 1 || result_M !== 32'd4) begin
      n_err++;
      $display("FAIL reset_then_add: edges=%0d res=%h want 1 4", e, result_M);
    end
    m_res = 32'd4;
  endtask

  task automatic test_slt_sll();
    int e; bit to;
    drive(3'd5, 32'hFFFF_FFFF, 1, 2'b00, 2'b00, 0, 1, 1'b1);
    run(e, to);
    n_vec++;
    if (to || result_M !== 32'd1) begin
      n_err++;
      $display("FAIL slt_neg: got %h want 00000001", result_M);
    end
    drive(3'd6, 1, 32'h21, 2'b00, 2'b00, 0, 1, 1'b1);
    run(e, to);
    n_vec++;
    if (to || result_M !== 32'd2) begin
      n_err++;
      $display("FAIL sll_mask: got %h want 00000002", result_M);
    end
    m_res = 32'd2;
  endtask

  task automatic test_random();
    int e; bit to;
    logic [2:0] op;
    logic [1:0] fa, fb;
    logic [31:0] a, bf, b, want, rs1, rs2, wb, rd;
    logic rw;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      fa = 2'($urandom_range(0, 3));
      fb = 2'($urandom_range(0, 3));
      rs1 = $urandom; rs2 = $urandom; wb = $urandom; rd = $urandom;
      rw = 1'($urandom_range(0, 1));
      drive(op, rs1, rs2, fa, fb, wb, rd, rw);
      if (op != 3'd7) use_imm = 1'($urandom_range(0, 1));
      imm = $urandom;
      a = fwd(fa, rs1, wb);
      bf = fwd(fb, rs2, wb);
      b = use_imm ? imm : bf;
      want = ref_alu(op, a, b);
      run(e, to);
      n_vec++;
      if (to || e != ((op == 3'd7) ? 33 : 1) || result_M !== want ||
          store_data_M !== bf || rd_M !== rd || regWrite_M !== rw ||
          out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rand_%0d op=%0d: edges=%0d res=%h st=%h rd=%h rw=%b v=%b want res=%h st=%h rd=%h rw=%b",
                 i, op, e, result_M, store_data_M, rd_M, regWrite_M,
                 out_valid, want, bf, rd, rw);
      end
      m_res = want;
      if ($urandom_range(0, 3) == 0) begin
        step();
        n_vec++;
        if (out_valid !== 1'b0 || regWrite_M !== 1'b0 ||
            rd_M !== 0 || result_M !== m_res) begin
          n_err++;
          $display("FAIL rand_bubble_%0d: v=%b rw=%b rd=%h res=%h want 0 0 0 %h",
                   i, out_valid, regWrite_M, rd_M, result_M, m_res);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_flush_mul();
    test_stall();
    test_reset_mid_mul();
    test_slt_sll();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
